// File: rtl/writeback_stage.sv
// Writeback stage of the pipelined MIPS core: M/W pipeline register, result
// select and register-file write controls, plus the fetch program counter.
module writeback_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        jumpM,
    input  logic        RegWriteM,
    input  logic [1:0]  MemtoRegM,
    input  logic [4:0]  WriteRegM,
    input  logic [31:0] ReadDataM,
    input  logic [31:0] ALUMultOutM,
    input  logic [31:0] PCPlus8M,
    input  logic        PCSrcD,
    input  logic        jumpD,
    input  logic [27:0] jumpDstD,
    input  logic [31:0] PCPlus4F,
    input  logic [31:0] PCBranchD,
    output logic        RegWriteW,
    output logic [4:0]  WriteRegW,
    output logic [31:0] ResultW,
    output logic [31:0] PC
);

    localparam logic [4:0] linkReg = 5'd31;

    logic        regWriteReg;
    logic [1:0]  memtoRegReg;
    logic [4:0]  writeRegReg;
    logic [31:0] readDataReg;
    logic [31:0] aluMultOutReg;
    logic [31:0] pcPlus8Reg;
    logic        jumpReg;
    logic [31:0] pcReg;
    logic [31:0] pcNext;

    // M/W register loads unconditionally; there is no stall or flush path.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regWriteReg   <= 1'b0;
            memtoRegReg   <= 2'b00;
            writeRegReg   <= 5'd0;
            readDataReg   <= 32'd0;
            aluMultOutReg <= 32'd0;
            pcPlus8Reg    <= 32'd0;
            jumpReg       <= 1'b0;
        end else begin
            regWriteReg   <= RegWriteM;
            memtoRegReg   <= MemtoRegM;
            writeRegReg   <= WriteRegM;
            readDataReg   <= ReadDataM;
            aluMultOutReg <= ALUMultOutM;
            pcPlus8Reg    <= PCPlus8M;
            jumpReg       <= jumpM;
        end
    end

    always_comb begin
        ResultW = aluMultOutReg;
        unique case (memtoRegReg)
            2'b01:   ResultW = readDataReg;
            2'b10:   ResultW = pcPlus8Reg;
            default: ResultW = aluMultOutReg;
        endcase
    end

    assign RegWriteW = regWriteReg;
    // jal links into $ra regardless of the encoded destination field.
    assign WriteRegW = (jumpReg && regWriteReg) ? linkReg : writeRegReg;

    // Jump outranks branch when decode raises both.
    always_comb begin
        pcNext = PCPlus4F;
        if (jumpD)
            pcNext = {PCPlus4F[31:28], jumpDstD};
        else if (PCSrcD)
            pcNext = PCBranchD;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            pcReg <= 32'd0;
        else
            pcReg <= pcNext;
    end

    assign PC = pcReg;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: expected W outputs and PC are queued when
// each step is driven and compared one edge later.
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        jumpM = 1'b0;
    logic        RegWriteM = 1'b0;
    logic [1:0]  MemtoRegM = 2'b00;
    logic [4:0]  WriteRegM = 5'd0;
    logic [31:0] ReadDataM = 32'd0;
    logic [31:0] ALUMultOutM = 32'd0;
    logic [31:0] PCPlus8M = 32'd0;
    logic        PCSrcD = 1'b0;
    logic        jumpD = 1'b0;
    logic [27:0] jumpDstD = 28'd0;
    logic [31:0] PCPlus4F = 32'd0;
    logic [31:0] PCBranchD = 32'd0;
    logic        RegWriteW;
    logic [4:0]  WriteRegW;
    logic [31:0] ResultW;
    logic [31:0] PC;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        rw;
        logic [4:0]  wr;
        logic [31:0] res;
        logic [31:0] pc;
    } exp_t;

    exp_t sb[$];

    writeback_stage dut (
        .clk(clk), .rst(rst), .jumpM(jumpM), .RegWriteM(RegWriteM),
        .MemtoRegM(MemtoRegM), .WriteRegM(WriteRegM), .ReadDataM(ReadDataM),
        .ALUMultOutM(ALUMultOutM), .PCPlus8M(PCPlus8M), .PCSrcD(PCSrcD),
        .jumpD(jumpD), .jumpDstD(jumpDstD), .PCPlus4F(PCPlus4F),
        .PCBranchD(PCBranchD), .RegWriteW(RegWriteW), .WriteRegW(WriteRegW),
        .ResultW(ResultW), .PC(PC)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic chkAll(input string tag, input exp_t e);
        chk({tag, ".RegWriteW"}, {31'd0, RegWriteW}, {31'd0, e.rw});
        chk({tag, ".WriteRegW"}, {27'd0, WriteRegW}, {27'd0, e.wr});
        chk({tag, ".ResultW"}, ResultW, e.res);
        chk({tag, ".PC"}, PC, e.pc);
        $display("%0t %s rw=%b wr=%0d res=%h pc=%h", $time, tag, RegWriteW, WriteRegW, ResultW, PC);
    endtask

    // Drive one cycle of M/D inputs at the falling edge, queue the expectation,
    // then compare just after the next rising edge.
    task automatic step(input string tag,
                        input logic rwM, input logic jM, input logic [1:0] mtr,
                        input logic [4:0] wrM, input logic [31:0] rd,
                        input logic [31:0] alu, input logic [31:0] p8,
                        input logic src, input logic jD, input logic [27:0] jdst,
                        input logic [31:0] p4, input logic [31:0] pb,
                        input exp_t e);
        exp_t got;
        @(negedge clk);
        RegWriteM = rwM; jumpM = jM; MemtoRegM = mtr; WriteRegM = wrM;
        ReadDataM = rd; ALUMultOutM = alu; PCPlus8M = p8;
        PCSrcD = src; jumpD = jD; jumpDstD = jdst; PCPlus4F = p4; PCBranchD = pb;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++; errors++;
            $error("FAIL %s scoreboard empty", tag);
        end else begin
            got = sb.pop_front();
            chkAll(tag, got);
        end
    endtask

    localparam exp_t zeroE = '0;

    initial begin
        // Reset held low while inputs toggle: outputs stay cleared everywhere.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            RegWriteM = 1'b1; jumpM = 1'b1; MemtoRegM = 2'b10; WriteRegM = $urandom_range(1, 31);
            ReadDataM = $urandom; ALUMultOutM = $urandom; PCPlus8M = $urandom;
            PCSrcD = 1'b1; PCBranchD = $urandom; PCPlus4F = $urandom;
            #2 chkAll("reset_mid", zeroE);
            @(posedge clk); #1;
            chkAll("reset_edge", zeroE);
        end

        @(negedge clk);
        rst = 1'b1;

        // Result mux, with sequential PC fetch advancing alongside.
        step("mux00", 1, 0, 2'b00, 5'd8, 32'h2222_2222, 32'h1111_1111, 32'h48, 0, 0, 28'd0,
             32'h4, 32'h0, '{1'b1, 5'd8, 32'h1111_1111, 32'h4});
        step("mux01", 1, 0, 2'b01, 5'd8, 32'h2222_2222, 32'h1111_1111, 32'h48, 0, 0, 28'd0,
             32'h8, 32'h0, '{1'b1, 5'd8, 32'h2222_2222, 32'h8});
        step("mux10", 1, 0, 2'b10, 5'd8, 32'h2222_2222, 32'h1111_1111, 32'h48, 0, 0, 28'd0,
             32'hC, 32'h0, '{1'b1, 5'd8, 32'h0000_0048, 32'hC});
        step("mux11", 1, 0, 2'b11, 5'd8, 32'h2222_2222, 32'h1111_1111, 32'h48, 0, 0, 28'd0,
             32'h10, 32'h0, '{1'b1, 5'd8, 32'h1111_1111, 32'h10});

        // jal links to r31; plain j leaves the index and write enable alone.
        step("jal", 1, 1, 2'b10, 5'd0, 32'h0, 32'h5, 32'h0040_0010, 0, 0, 28'd0,
             32'h14, 32'h0, '{1'b1, 5'd31, 32'h0040_0010, 32'h14});
        step("j", 0, 1, 2'b10, 5'd0, 32'h0, 32'h5, 32'h0040_0010, 0, 0, 28'd0,
             32'h18, 32'h0, '{1'b0, 5'd0, 32'h0040_0010, 32'h18});
        step("jal_nolink", 1, 0, 2'b00, 5'd12, 32'h0, 32'hDEAD_BEEF, 32'h0, 0, 0, 28'd0,
             32'h1C, 32'h0, '{1'b1, 5'd12, 32'hDEAD_BEEF, 32'h1C});

        // Branch, then jump+branch where the jump must win.
        step("branch", 0, 0, 2'b00, 5'd3, 32'h0, 32'h7, 32'h0, 1, 0, 28'd0,
             32'h20, 32'h100, '{1'b0, 5'd3, 32'h7, 32'h100});
        step("jump_prio", 0, 0, 2'b00, 5'd3, 32'h0, 32'h7, 32'h0, 1, 1, 28'h0000_200,
             32'h1000_0004, 32'h100, '{1'b0, 5'd3, 32'h7, 32'h1000_0200});
        step("jump_only", 0, 0, 2'b00, 5'd3, 32'h0, 32'h7, 32'h0, 0, 1, 28'hABC_DEF0,
             32'hF000_0000, 32'h100, '{1'b0, 5'd3, 32'h7, 32'hFABC_DEF0});
        step("seq_wrap", 0, 0, 2'b00, 5'd3, 32'h0, 32'h7, 32'h0, 0, 0, 28'd0,
             32'hFFFF_FFFC, 32'h100, '{1'b0, 5'd3, 32'h7, 32'hFFFF_FFFC});

        // Mid-run reset pulse between edges clears state immediately.
        @(negedge clk);
        #2 rst = 1'b0;
        #1 chkAll("midrst", zeroE);
        #1 rst = 1'b1;
        #0.5 chkAll("midrst_rel", zeroE);
        step("resume", 1, 0, 2'b01, 5'd9, 32'h3333_3333, 32'h0, 32'h0, 0, 0, 28'd0,
             32'h20, 32'h0, '{1'b1, 5'd9, 32'h3333_3333, 32'h20});

        if (sb.size() != 0) begin
            checks++; errors++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
